cnn_mac_pipe: RTL and testbench



---
 rtl/cnn_mac_pkg.sv | 29 ++
 rtl/cnn_mac_mul_stage.sv | 70 +++++++
 rtl/cnn_mac_pipe.sv | 100 ++++++++++
 tb/tb_cnn_mac_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mac_pkg.sv
// Shared mode constants, saturation bounds and width checks for the CNN MAC datapath.
package cnn_mac_pkg;

    localparam bit MAC_UNSIGNED = 1'b0;
    localparam bit MAC_SIGNED   = 1'b1;
    localparam bit MAC_WRAP     = 1'b0;
    localparam bit MAC_SAT      = 1'b1;

    // Widest accumulator the bound helpers can describe.
    localparam int MAC_MAX_W = 64;

    function automatic logic [MAC_MAX_W-1:0] sat_max(input int width, input bit is_signed);
        logic [MAC_MAX_W-1:0] all_ones;
        all_ones = '1;
        return all_ones >> (MAC_MAX_W - width + int'(is_signed));
    endfunction

    function automatic logic [MAC_MAX_W-1:0] sat_min(input int width, input bit is_signed);
        logic [MAC_MAX_W-1:0] m;
        m = '0;
        if (is_signed) m[width-1] = 1'b1;
        return m;
    endfunction

    function automatic bit mac_widths_ok(input int a_w, input int b_w, input int acc_w);
        return (acc_w >= a_w + b_w) && (acc_w <= MAC_MAX_W);
    endfunction

endpackage

// File: rtl/cnn_mac_mul_stage.sv
// Operand register (S1) and full-precision product register (S2), sized for a DSP48 slice.
module cnn_mac_mul_stage
    import cnn_mac_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 11,
    parameter int unsigned B_WIDTH   = 13,
    parameter int unsigned ACC_WIDTH = 32,
    parameter bit          SIGNED    = MAC_UNSIGNED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    output logic                 prod_valid,
    output logic                 prod_first,
    output logic                 prod_last,
    output logic [ACC_WIDTH-1:0] prod
);

    localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

    logic [A_WIDTH-1:0]   a_r;
    logic [B_WIDTH-1:0]   b_r;
    logic                 s1_valid, s1_first, s1_last;
    logic [ACC_WIDTH-1:0] prod_ext;

    generate
        if (SIGNED) begin : g_signed
            logic signed [P_WIDTH-1:0] p;
            assign p        = P_WIDTH'($signed(a_r)) * P_WIDTH'($signed(b_r));
            assign prod_ext = ACC_WIDTH'(p);
        end else begin : g_unsigned
            logic [P_WIDTH-1:0] p;
            assign p        = P_WIDTH'(a_r) * P_WIDTH'(b_r);
            assign prod_ext = ACC_WIDTH'(p);
        end
    endgenerate

    // Data registers carry no reset so they pack into the DSP pipeline registers.
    always_ff @(posedge clk) begin
        if (ce) begin
            a_r  <= din0;
            b_r  <= din1;
            prod <= prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            prod_valid <= 1'b0;
            prod_first <= 1'b0;
            prod_last  <= 1'b0;
        end else if (ce) begin
            s1_valid   <= in_valid;
            s1_first   <= in_valid & in_first;
            s1_last    <= in_valid & in_last;
            prod_valid <= s1_valid;
            prod_first <= s1_first;
            prod_last  <= s1_last;
        end
    end

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined multiply-accumulate: one product per clock, framed into one dot product per vector.
module cnn_mac_pipe
    import cnn_mac_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 11,
    parameter int unsigned B_WIDTH   = 13,
    parameter int unsigned ACC_WIDTH = 32,
    parameter bit          SIGNED    = MAC_UNSIGNED,
    parameter bit          SATURATE  = MAC_WRAP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] dout,
    output logic                 ovf
);

    localparam int MSB = ACC_WIDTH - 1;
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED));
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED));

    generate
        if (!mac_widths_ok(A_WIDTH, B_WIDTH, ACC_WIDTH)) begin : g_bad_widths
            $error("cnn_mac_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH and <= MAC_MAX_W");
        end
    endgenerate

    logic                 prod_valid, prod_first, prod_last;
    logic [ACC_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0] acc, acc_next, sum;
    logic [ACC_WIDTH:0]   sum_u;
    logic                 sticky, sticky_next, ovf_beat;

    cnn_mac_mul_stage #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED)
    ) u_mul (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .in_last    (in_last),
        .din0       (din0),
        .din1       (din1),
        .prod_valid (prod_valid),
        .prod_first (prod_first),
        .prod_last  (prod_last),
        .prod       (prod)
    );

    // Signed overflow: like-signed operands whose sum flips sign; unsigned: carry out.
    always_comb begin
        sum_u = {1'b0, acc} + {1'b0, prod};
        sum   = sum_u[ACC_WIDTH-1:0];
        if (SIGNED) ovf_beat = (acc[MSB] == prod[MSB]) && (sum[MSB] != acc[MSB]);
        else        ovf_beat = sum_u[ACC_WIDTH];
        acc_next    = sum;
        sticky_next = sticky | ovf_beat;
        if (prod_first) begin
            acc_next    = prod;
            sticky_next = 1'b0;
        end else if (ovf_beat && SATURATE) begin
            acc_next = (SIGNED && acc[MSB]) ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= prod_valid & prod_last;
            if (prod_valid) begin
                if (prod_last) begin
                    // Clearing here lets a vector that omits first still start from zero.
                    acc    <= '0;
                    sticky <= 1'b0;
                    dout   <= acc_next;
                    ovf    <= sticky_next;
                end else begin
                    acc    <= acc_next;
                    sticky <= sticky_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Bench for cnn_mac_pipe: three configurations share one stimulus stream, checked against a reference model.
module tb_cnn_mac_pipe;

    typedef struct packed {
        logic [15:0]      edge_n;
        logic [2:0]       ovf;
        logic [2:0][31:0] dout;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic        clk, reset, ce, in_valid, in_first, in_last;
    logic [10:0] din0;
    logic [12:0] din1;
    logic        v0, v1, v2, o0, o1, o2;
    logic [31:0] dout0;
    logic [23:0] dout1, dout2;

    logic [W-1:0] exp_q[$];
    longint       acc_m[3];
    bit           stk_m[3];
    int           ce_cnt;
    int           checks, failures;
    exp_t         cur;
    bit           cur_valid;

    cnn_mac_pipe u_dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(v0), .dout(dout0), .ovf(o0)
    );

    cnn_mac_pipe #(.ACC_WIDTH(24), .SIGNED(1'b1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(v1), .dout(dout1), .ovf(o1)
    );

    cnn_mac_pipe #(.ACC_WIDTH(24), .SIGNED(1'b1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .out_valid(v2), .dout(dout2), .ovf(o2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model; k=0 unsigned wrap 32b, k=1 signed saturate 24b, k=2 signed wrap 24b.
    task automatic accept(input logic [10:0] a, input logic [12:0] b, input bit f, input bit l);
        exp_t   e;
        longint p, s, lo, hi, mask;
        bit     sgn, o;
        int     w;
        e        = '0;
        e.edge_n = 16'(ce_cnt + 3);
        for (int k = 0; k < 3; k++) begin
            sgn  = (k != 0);
            w    = (k == 0) ? 32 : 24;
            mask = (longint'(1) << w) - 1;
            lo   = sgn ? -(longint'(1) << (w - 1)) : 0;
            hi   = sgn ? (longint'(1) << (w - 1)) - 1 : mask;
            p    = sgn ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
            if (f) begin
                acc_m[k] = p;
                stk_m[k] = 1'b0;
            end else begin
                s = acc_m[k] + p;
                o = (s < lo) || (s > hi);
                if (o) begin
                    if (k == 1) s = (s > hi) ? hi : lo;
                    else begin
                        s = s & mask;
                        if (sgn && s > hi) s = s - (mask + 1);
                    end
                end
                acc_m[k] = s;
                stk_m[k] = stk_m[k] | o;
            end
            if (l) begin
                e.dout[k] = 32'(acc_m[k] & mask);
                e.ovf[k]  = stk_m[k];
                acc_m[k]  = 0;
                stk_m[k]  = 1'b0;
            end
        end
        if (l) exp_q.push_back(W'(e));
    endtask

    // driver tasks (all called at a negedge)
    task automatic beat(input logic [10:0] a, input logic [12:0] b, input bit f, input bit l);
        ce = 1'b1; in_valid = 1'b1; in_first = f; in_last = l; din0 = a; din1 = b;
        accept(a, b, f, l);
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            ce = 1'b1; in_valid = 1'b0;
            in_first = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
            din0 = 11'($urandom); din1 = 13'($urandom);
            @(negedge clk);
        end
        in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            ce = 1'b0; in_valid = 1'($urandom_range(0, 1));
            in_first = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
            din0 = 11'($urandom); din1 = 13'($urandom);
            @(negedge clk);
        end
        ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            acc_m[k] = 0;
            stk_m[k] = 1'b0;
        end
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // scoreboard: a result is due on the exact ce-edge recorded at acceptance
    always @(posedge clk) begin : monitor
        bit               ce_s, rst_s;
        exp_t             e;
        logic [2:0][31:0] od;
        logic [2:0]       ov, oo;
        ce_s  = ce;
        rst_s = reset;
        #1;
        od[0] = dout0; od[1] = {8'd0, dout1}; od[2] = {8'd0, dout2};
        ov = {v2, v1, v0};
        oo = {o2, o1, o0};
        if (rst_s) begin
            exp_q.delete();
            cur       = '0;
            cur_valid = 1'b0;
        end else if (ce_s) begin
            ce_cnt++;
            cur_valid = 1'b0;
            if (exp_q.size() != 0) begin
                e = exp_t'(exp_q[0]);
                if (e.edge_n == 16'(ce_cnt)) begin
                    cur       = e;
                    cur_valid = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("dut%0d_out_valid", k), 32'(ov[k]), 32'(cur_valid));
            check_eq($sformatf("dut%0d_dout", k), od[k], cur.dout[k]);
            check_eq($sformatf("dut%0d_ovf", k), 32'(oo[k]), 32'(cur.ovf[k]));
        end
    end

    initial begin
        int len;
        checks = 0; failures = 0; ce_cnt = 0;
        cur = '0; cur_valid = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
        do_reset(2);

        // full-scale single-term product
        beat(11'd2047, 13'd8191, 1'b1, 1'b1);
        bubble(4);

        // back-to-back vectors, then a repeat of the single-beat one
        beat(11'd1, 13'd2, 1'b1, 1'b0);
        beat(11'd3, 13'd4, 1'b0, 1'b0);
        beat(11'd5, 13'd6, 1'b0, 1'b0);
        beat(11'd7, 13'd8, 1'b0, 1'b1);
        beat(11'd10, 13'd10, 1'b1, 1'b1);
        beat(11'd10, 13'd10, 1'b1, 1'b1);
        bubble(4);

        // gaps and ce stalls inside a vector; result held through a stall
        beat(11'd1, 13'd2, 1'b1, 1'b0);
        bubble(1);
        beat(11'd3, 13'd4, 1'b0, 1'b0);
        stall(2);
        beat(11'd5, 13'd6, 1'b0, 1'b0);
        bubble(2);
        beat(11'd7, 13'd8, 1'b0, 1'b1);
        bubble(2);
        stall(2);
        bubble(3);

        // three beats of (-1024, -4096): saturates / wraps in the 24-bit signed units
        beat(11'h400, 13'h1000, 1'b1, 1'b0);
        beat(11'h400, 13'h1000, 1'b0, 1'b0);
        beat(11'h400, 13'h1000, 1'b0, 1'b1);
        bubble(4);

        // reset in mid-vector discards it
        beat(11'd5, 13'd5, 1'b1, 1'b0);
        beat(11'd6, 13'd6, 1'b0, 1'b0);
        do_reset(1);
        bubble(4);
        beat(11'd2, 13'd3, 1'b1, 1'b1);
        bubble(4);

        // accumulator clears after last even without first
        beat(11'd9, 13'd9, 1'b1, 1'b1);
        beat(11'd4, 13'd5, 1'b0, 1'b0);
        beat(11'd1, 13'd1, 1'b0, 1'b1);
        bubble(4);

        // random vectors with bubbles and stalls
        for (int v = 0; v < 25; v++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) bubble(1);
                if ($urandom_range(0, 5) == 0) stall($urandom_range(1, 2));
                beat(11'($urandom), 13'($urandom), i == 0, i == len - 1);
            end
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) bubble(1);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        bubble(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
